// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter and sequencer for the shared 16-bit ALU.
// A granted request is latched onto the ALU inputs, the ALU result and condition codes
// are captured one cycle later, and they are returned with the requester ID.
// Optional macro ALU_ARB_MUL2_EN: multiply (opcode 1111) holds the ALU inputs for an
// extra EXEC2 cycle before capture. Without it every opcode spends one cycle in EXEC.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_opa,
    input  logic [WIDTH-1:0] req0_opb,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_opa,
    input  logic [WIDTH-1:0] req1_opb,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_valA,
    output logic [WIDTH-1:0] alu_valB,
    output logic [OPW-1:0]   alu_aluop,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_cc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_cc,
    output logic             rsp_err,
    output logic             busy
);

    // Bit n set means opcode n is a defined ALU operation.
    localparam logic [15:0]    DEF_MASK = 16'b1111_1011_1110_0110;
    localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
`ifdef ALU_ARB_MUL2_EN
    localparam logic [OPW-1:0] OP_MUL   = OPW'(15);
`endif

`ifdef ALU_ARB_MUL2_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2, EXEC2 = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic             prio;
    logic             cur_id;
    logic             cur_err;
    logic             accept;
    logic             win_id;
    logic             win_def;
    logic             capture;
    logic [WIDTH-1:0] win_opa;
    logic [WIDTH-1:0] win_opb;
    logic [OPW-1:0]   win_op;

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> EXEC -> (EXEC2 for multiply) -> RESP -> IDLE on rsp_ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = EXEC;
`ifdef ALU_ARB_MUL2_EN
            EXEC: state_next = (alu_aluop == OP_MUL) ? EXEC2 : RESP;
            EXEC2: state_next = RESP;
`else
            EXEC: state_next = RESP;
`endif
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and grant: only IDLE grants, the prio port wins a tie, capture marks the last ALU cycle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            req0_ready = req0_valid & (~req1_valid | ~prio);
            req1_ready = req1_valid & (~req0_valid | prio);
        end
        accept    = req0_ready | req1_ready;
        win_id    = req1_ready;
        win_opa   = win_id ? req1_opa : req0_opa;
        win_opb   = win_id ? req1_opb : req0_opb;
        win_op    = win_id ? req1_op  : req0_op;
        win_def   = DEF_MASK[win_op];
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        alu_sub   = (alu_aluop == OP_SUB);
`ifdef ALU_ARB_MUL2_EN
        capture   = ((state == EXEC) && (alu_aluop != OP_MUL)) || (state == EXEC2);
`else
        capture   = (state == EXEC);
`endif
    end

    // Datapath registers: latch the winner (undefined ops never reach the ALU), capture the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio       <= 1'b0;
            cur_id     <= 1'b0;
            cur_err    <= 1'b0;
            alu_valA   <= '0;
            alu_valB   <= '0;
            alu_aluop  <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cc     <= 4'b0000;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                prio    <= ~win_id;
                cur_id  <= win_id;
                cur_err <= ~win_def;
                if (win_def) begin
                    alu_valA  <= win_opa;
                    alu_valB  <= win_opb;
                    alu_aluop <= win_op;
                end else begin
                    alu_valA  <= '0;
                    alu_valB  <= '0;
                    alu_aluop <= '0;
                end
            end
            if (capture) begin
                rsp_id     <= cur_id;
                rsp_err    <= cur_err;
                rsp_result <= cur_err ? '0 : alu_result;
                rsp_cc     <= cur_err ? 4'b0000 : alu_cc;
            end
            if ((state == RESP) && rsp_ready) begin
                alu_valA  <= '0;
                alu_valB  <= '0;
                alu_aluop <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// A transaction-level model (one op in flight, its age in cycles and a priority bit)
// predicts every output each cycle; a vector table and hand sequences cover the
// documented corner cases. The ALU itself is modelled here as a combinational function.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_opa, req0_opb, req1_opa, req1_opb;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] alu_valA, alu_valB, alu_result;
    logic [3:0]  alu_aluop, alu_cc;
    logic        alu_sub;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_cc;

    int n_cmp = 0;
    int n_bad = 0;

    // transaction-level model state
    bit          m_inflight;
    int          m_age;
    int          m_lat;
    bit          m_prio;
    bit          m_id;
    logic [15:0] m_a, m_b;
    logic [3:0]  m_op;
    bit          m_acc0, m_acc1;

    typedef struct {
        bit          port;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [15:0] r;
        logic [3:0]  cc;
        bit          err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_op(req1_op),
        .alu_valA(alu_valA), .alu_valB(alu_valB), .alu_aluop(alu_aluop), .alu_sub(alu_sub),
        .alu_result(alu_result), .alu_cc(alu_cc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cc(rsp_cc), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU: returns {N,Z,C,V,result}.
    function automatic logic [19:0] aluFn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        logic [16:0] w;
        logic [15:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h1: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'h2: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'hF: r = a * b;
            default: r = a ^ (b + {12'd0, op});
        endcase
        return {r[15], (r == 16'd0), c, v, r};
    endfunction

    assign {alu_cc, alu_result} = aluFn(alu_valA, alu_valB, alu_aluop);

    function automatic bit isDef(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int latOf(input logic [3:0] op);
        int l;
        l = 2;
`ifdef ALU_ARB_MUL2_EN
        if (op == 4'hF) l = 3;
`endif
        return l;
    endfunction

    function automatic logic [15:0] rndOperand();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic modelGrant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_inflight) begin
            if (req0_valid && req1_valid) begin
                g0 = !m_prio;
                g1 = m_prio;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
    endtask

    task automatic modelCheck();
        bit          g0, g1, rv, d;
        logic [19:0] e;
        modelGrant(g0, g1);
        rv = m_inflight && (m_age >= m_lat);
        checkOutput("busy", 32'(busy), 32'(m_inflight));
        checkOutput("req0_ready", 32'(req0_ready), 32'(g0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(g1));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            d = isDef(m_op);
            e = d ? aluFn(m_a, m_b, m_op) : 20'd0;
            checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
            checkOutput("rsp_result", 32'(rsp_result), 32'(e[15:0]));
            checkOutput("rsp_cc", 32'(rsp_cc), 32'(e[19:16]));
            checkOutput("rsp_err", 32'(rsp_err), 32'(!d));
        end
        if (!m_inflight) begin
            checkOutput("idle_valA", 32'(alu_valA), 0);
            checkOutput("idle_valB", 32'(alu_valB), 0);
            checkOutput("idle_aluop", 32'(alu_aluop), 0);
            checkOutput("idle_sub", 32'(alu_sub), 0);
        end else if (m_age < m_lat) begin
            d = isDef(m_op);
            checkOutput("exec_aluop", 32'(alu_aluop), d ? 32'(m_op) : 0);
            checkOutput("exec_sub", 32'(alu_sub), 32'(d && (m_op == 4'h2)));
            if (d) begin
                checkOutput("exec_valA", 32'(alu_valA), 32'(m_a));
                checkOutput("exec_valB", 32'(alu_valB), 32'(m_b));
            end
        end
    endtask

    task automatic modelAdvance();
        bit g0, g1;
        modelGrant(g0, g1);
        m_acc0 = 1'b0;
        m_acc1 = 1'b0;
        if (!reset_n) begin
            m_inflight = 1'b0;
            m_prio     = 1'b0;
        end else if (!m_inflight) begin
            if (g0 || g1) begin
                m_inflight = 1'b1;
                m_age      = 1;
                m_id       = g1;
                m_a        = g1 ? req1_opa : req0_opa;
                m_b        = g1 ? req1_opb : req0_opb;
                m_op       = g1 ? req1_op  : req0_op;
                m_lat      = latOf(m_op);
                m_prio     = !g1;
                m_acc0     = g0;
                m_acc1     = g1;
            end
        end else if (m_age >= m_lat) begin
            if (rsp_ready) m_inflight = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    // one clock: compare at the falling edge, advance the model at the rising edge
    task automatic cycle();
        @(negedge clk);
        modelCheck();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic dropAccepted();
        if (m_acc0) req0_valid = 1'b0;
        if (m_acc1) req1_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!m_inflight && !req0_valid && !req1_valid) return;
            cycle();
            dropAccepted();
        end
        failNow("drain_timeout");
    endtask

    task automatic driveReq(input bit port, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        if (port) begin
            req1_valid = 1'b1; req1_opa = a; req1_opb = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_opa = a; req0_opb = b; req0_op = op;
        end
    endtask

    // one table vector: single request, check EXEC controls, latency and the response payload
    task automatic applyStimulus(input vec_t v);
        bit got;
        int el;
        el = latOf(v.op);
        got = 1'b0;
        rsp_ready = 1'b1;
        driveReq(v.port, v.a, v.b, v.op);
        #1;
        checkOutput("tbl_ready", 32'(v.port ? req1_ready : req0_ready), 1);
        cycle();
        dropAccepted();
        for (int k = 1; k <= 6 && !got; k++) begin
            if (rsp_valid) begin
                got = 1'b1;
                checkOutput("tbl_latency", 32'(k), 32'(el));
                checkOutput("tbl_rsp_id", 32'(rsp_id), 32'(v.port));
                checkOutput("tbl_rsp_result", 32'(rsp_result), 32'(v.r));
                checkOutput("tbl_rsp_cc", 32'(rsp_cc), 32'(v.cc));
                checkOutput("tbl_rsp_err", 32'(rsp_err), 32'(v.err));
            end else if (k == 1) begin
                checkOutput("tbl_aluop", 32'(alu_aluop), v.err ? 0 : 32'(v.op));
                checkOutput("tbl_sub", 32'(alu_sub), 32'(v.op == 4'h2));
            end
            cycle();
        end
        if (!got) failNow("tbl_rsp_timeout");
        drain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ids[$];
        int cyc[$];

        vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 4'h1, 16'h8000, 4'b1001, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0005, 4'h2, 16'h0000, 4'b0100, 1'b0};
        vecs[2] = '{1'b0, 16'h1234, 16'h00FF, 4'h3, 16'h0000, 4'b0000, 1'b1};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 4'h1, 16'h0000, 4'b0110, 1'b0};
        vecs[4] = '{1'b0, 16'h0003, 16'h0004, 4'hF, 16'h000C, 4'b0000, 1'b0};
        vecs[5] = '{1'b1, 16'h0000, 16'h0001, 4'h2, 16'hFFFF, 4'b1010, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'hFFFF, 4'h1, 16'h7FFF, 4'b0011, 1'b0};
        vecs[7] = '{1'b1, 16'h00AA, 16'h0055, 4'hA, 16'h0000, 4'b0000, 1'b1};

        reset_n = 1'b0;
        req0_valid = 1'b0; req0_opa = '0; req0_opb = '0; req0_op = '0;
        req1_valid = 1'b0; req1_opa = '0; req1_opb = '0; req1_op = '0;
        rsp_ready = 1'b0;
        m_inflight = 1'b0; m_prio = 1'b0; m_age = 0; m_lat = 2;
        m_id = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_acc0 = 1'b0; m_acc1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_result", 32'(rsp_result), 0);
        checkOutput("rst_aluop", 32'(alu_aluop), 0);

        $display("[TB] vector table");
        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] both ports continuously valid");
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        driveReq(1'b0, 16'h0001, 16'h0002, 4'h1);
        driveReq(1'b1, 16'h0010, 16'h0020, 4'h1);
        for (int c = 0; c < 13; c++) begin
            #1;
            if (req0_ready) begin ids.push_back(0); cyc.push_back(c); end
            if (req1_ready) begin ids.push_back(1); cyc.push_back(c); end
            cycle();
        end
        checkOutput("alt_count", 32'(ids.size()), 5);
        for (int i = 0; i < ids.size() && i < 5; i++) begin
            checkOutput("alt_id", 32'(ids[i]), 32'(i % 2));
            checkOutput("alt_cycle", 32'(cyc[i]), 32'(3 * i));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        $display("[TB] response back-pressure");
        rsp_ready = 1'b0;
        driveReq(1'b0, 16'h0010, 16'h0020, 4'h1);
        #1;
        checkOutput("bp_ready0", 32'(req0_ready), 1);
        cycle();
        req0_valid = 1'b0;
        driveReq(1'b1, 16'h0100, 16'h0001, 4'h2);
        cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
            checkOutput("bp_rsp_result", 32'(rsp_result), 32'h0030);
            checkOutput("bp_rsp_cc", 32'(rsp_cc), 0);
            checkOutput("bp_rsp_id", 32'(rsp_id), 0);
            checkOutput("bp_ready1_low", 32'(req1_ready), 0);
            cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        #1;
        checkOutput("bp_idle_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("bp_ready1_high", 32'(req1_ready), 1);
        cycle();
        dropAccepted();
        drain();

        $display("[TB] reset during EXEC");
        driveReq(1'b0, 16'h0001, 16'h0002, 4'h1);
        cycle();
        req0_valid = 1'b0;
        checkOutput("rx_busy_exec", 32'(busy), 1);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        #1;
        checkOutput("rx_busy", 32'(busy), 0);
        checkOutput("rx_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rx_rsp_id", 32'(rsp_id), 0);
        checkOutput("rx_rsp_result", 32'(rsp_result), 0);
        checkOutput("rx_rsp_cc", 32'(rsp_cc), 0);
        checkOutput("rx_rsp_err", 32'(rsp_err), 0);
        checkOutput("rx_valA", 32'(alu_valA), 0);
        checkOutput("rx_valB", 32'(alu_valB), 0);
        checkOutput("rx_aluop", 32'(alu_aluop), 0);
        checkOutput("rx_sub", 32'(alu_sub), 0);
        for (int i = 0; i < 3; i++) cycle();
        driveReq(1'b0, 16'h0004, 16'h0004, 4'h5);
        driveReq(1'b1, 16'h0008, 16'h0008, 4'h6);
        #1;
        checkOutput("rx_prio_ready0", 32'(req0_ready), 1);
        checkOutput("rx_prio_ready1", 32'(req1_ready), 0);
        drain();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            if (!req0_valid && $urandom_range(0, 2) == 0)
                driveReq(1'b0, rndOperand(), rndOperand(), 4'($urandom_range(0, 15)));
            if (!req1_valid && $urandom_range(0, 2) == 0)
                driveReq(1'b1, rndOperand(), rndOperand(), 4'($urandom_range(0, 15)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            dropAccepted();
        end
        reset_n = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
